// File: rtl/dsp_mac_sequencer_if.sv
// Stream bundle for the MAC sequencer: operand-pair input stream and
// dot-product result stream. "master" is the upstream producer / result
// consumer, "slave" is the sequencer itself.
interface dsp_mac_sequencer_if;
    logic        s_valid;
    logic        s_ready;
    logic [17:0] s_a;
    logic [17:0] s_b;
    logic        m_valid;
    logic        m_ready;
    logic [47:0] m_data;

    modport master (
        output s_valid, s_a, s_b, m_ready,
        input  s_ready, m_valid, m_data
    );

    modport slave (
        input  s_valid, s_a, s_b, m_ready,
        output s_ready, m_valid, m_data
    );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Control stage feeding a DSP48A1 slice: accepts N_TAPS (a, b) pairs, steers
// the slice OPMODE so that P accumulates their products, then captures P and
// offers it on the result stream. One dot product in flight at a time.
module dsp_mac_sequencer #(
    parameter int N_TAPS   = 8,
    parameter int CNT_W    = 12,
    parameter int MULT_LAT = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    dsp_mac_sequencer_if.slave  bus,
    output logic [17:0]         dsp_a,
    output logic [17:0]         dsp_b,
    output logic [7:0]          dsp_opmode,
    input  logic [47:0]         dsp_p,
    output logic                busy
);
    // OPMODE encodings (post-adder add, no pre-adder, carry-in 0)
    localparam logic [7:0] OP_CLR   = 8'h00;  // X=0, Z=0
    localparam logic [7:0] OP_FIRST = 8'h01;  // X=M, Z=0
    localparam logic [7:0] OP_ACC   = 8'h09;  // X=M, Z=P
    localparam logic [7:0] OP_HOLD  = 8'h08;  // X=0, Z=P

    localparam int DRN_W = $clog2(MULT_LAT + 1);
    // Tap comparison is one bit wider so N_TAPS = 2^CNT_W is reachable.
    localparam logic [CNT_W:0]   LAST_TAP   = (CNT_W + 1)'(N_TAPS);
    localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(MULT_LAT);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [DRN_W-1:0]   drain_reg, drain_next;
    logic               m_valid_reg, m_valid_next;
    logic [47:0]        m_data_reg, m_data_next;
    logic               run_reg;
    logic [7:0]         opcode_next;
    logic [CNT_W:0]     count_inc;
    logic               s_ready_int;
    logic               take;

    // run_reg keeps s_ready low while reset is applied and until the first
    // clock after release, without routing RST_N into the datapath.
    assign s_ready_int = run_reg && ((state_reg == IDLE) || (state_reg == ACCUM));
    assign take        = bus.s_valid && s_ready_int;
    assign count_inc   = {1'b0, count_reg} + {{CNT_W{1'b0}}, 1'b1};

    // Operands go straight to the slice A1/B1 registers; zeroed when no pair
    // is taken so idle cycles present a clean zero.
    assign dsp_a = take ? bus.s_a : 18'd0;
    assign dsp_b = take ? bus.s_b : 18'd0;

    assign bus.s_ready = s_ready_int;
    assign bus.m_valid = m_valid_reg;
    assign bus.m_data  = m_data_reg;
    assign busy        = (state_reg != IDLE);

    // State register and captured result
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            drain_reg   <= '0;
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            run_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            drain_reg   <= drain_next;
            m_valid_reg <= m_valid_next;
            m_data_reg  <= m_data_next;
            run_reg     <= 1'b1;
        end
    end

    // Next-state logic and the opcode issued this cycle
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        drain_next   = drain_reg;
        m_valid_next = m_valid_reg;
        m_data_next  = m_data_reg;
        opcode_next  = OP_HOLD;
        case (state_reg)
            IDLE: begin
                opcode_next = OP_CLR;
                if (take) begin
                    opcode_next = OP_FIRST;
                    count_next  = CNT_W'(1);
                    if (N_TAPS == 1) begin
                        drain_next = DRAIN_LOAD;
                        state_next = DRAIN;
                    end else begin
                        state_next = ACCUM;
                    end
                end
            end
            ACCUM: begin
                // A bubble issues HOLD so P is left untouched.
                if (take) begin
                    opcode_next = OP_ACC;
                    count_next  = count_inc[CNT_W-1:0];
                    if (count_inc == LAST_TAP) begin
                        drain_next = DRAIN_LOAD;
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Counter hits zero exactly when the last product is in P.
                if (drain_reg == '0) begin
                    m_data_next  = dsp_p;
                    m_valid_next = 1'b1;
                    state_next   = OUT;
                end else begin
                    drain_next = drain_reg - DRN_W'(1);
                end
            end
            OUT: begin
                if (m_valid_reg && bus.m_ready) begin
                    m_valid_next = 1'b0;
                    count_next   = '0;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Opcode delay line: MULT_LAT-1 stages so each opcode lands in the slice
    // OPMODE register together with its own product on M.
    generate
        if (MULT_LAT > 1) begin : g_dly
            genvar gi;
            for (gi = 0; gi < MULT_LAT - 1; gi++) begin : g_stage
                logic [7:0] stage_reg;
                if (gi == 0) begin : g_head
                    // First stage takes the freshly issued opcode
                    always_ff @(posedge CLK or negedge RST_N) begin
                        if (!RST_N) stage_reg <= OP_CLR;
                        else        stage_reg <= opcode_next;
                    end
                end else begin : g_tail
                    // Later stages shift the opcode along
                    always_ff @(posedge CLK or negedge RST_N) begin
                        if (!RST_N) stage_reg <= OP_CLR;
                        else        stage_reg <= g_stage[gi-1].stage_reg;
                    end
                end
            end
            assign dsp_opmode = g_stage[MULT_LAT-2].stage_reg;
        end else begin : g_nodly
            assign dsp_opmode = opcode_next;
        end
    endgenerate
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: behavioural DSP48A1 slice, scoreboard of
// expected dot products and opcodes, directed cases plus random batches.
module tb_dsp_mac_sequencer;
    localparam int ML = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // ---------------- main DUT: N_TAPS=4 ----------------
    dsp_mac_sequencer_if bus();
    logic [17:0] dsp_a, dsp_b;
    logic [7:0]  dsp_opmode;
    logic [47:0] dsp_p;
    logic        busy;

    dsp_mac_sequencer #(.N_TAPS(4), .CNT_W(12), .MULT_LAT(ML)) dut (
        .CLK(clk), .RST_N(rst_n), .bus(bus.slave),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
        .dsp_p(dsp_p), .busy(busy)
    );

    // Slice model: A1/B1 reg + MREG (product delayed ML), OPMODEREG, PREG
    logic [35:0] m_pipe [ML];
    logic [7:0]  opm_reg;
    logic [47:0] p_reg = 48'hDEAD_BEEF_CAFE;
    always @(posedge clk) begin
        m_pipe[0] <= 36'(dsp_a) * 36'(dsp_b);
        for (int i = 1; i < ML; i++) m_pipe[i] <= m_pipe[i-1];
        opm_reg <= dsp_opmode;
        p_reg <= ((opm_reg[1:0] == 2'b01) ? 48'(m_pipe[ML-1]) : 48'd0)
               + ((opm_reg[3:2] == 2'b10) ? p_reg : 48'd0);
    end
    assign dsp_p = p_reg;

    // ---------------- second DUT: N_TAPS=1 ----------------
    dsp_mac_sequencer_if bus1();
    logic [17:0] d1_a, d1_b;
    logic [7:0]  d1_op;
    logic [47:0] d1_p;
    logic        busy1;

    dsp_mac_sequencer #(.N_TAPS(1), .CNT_W(4), .MULT_LAT(ML)) dut1 (
        .CLK(clk), .RST_N(rst_n), .bus(bus1.slave),
        .dsp_a(d1_a), .dsp_b(d1_b), .dsp_opmode(d1_op),
        .dsp_p(d1_p), .busy(busy1)
    );

    logic [35:0] m1_pipe [ML];
    logic [7:0]  opm1_reg;
    logic [47:0] p1_reg = 48'h1234_5678_9ABC;
    always @(posedge clk) begin
        m1_pipe[0] <= 36'(d1_a) * 36'(d1_b);
        for (int i = 1; i < ML; i++) m1_pipe[i] <= m1_pipe[i-1];
        opm1_reg <= d1_op;
        p1_reg <= ((opm1_reg[1:0] == 2'b01) ? 48'(m1_pipe[ML-1]) : 48'd0)
                + ((opm1_reg[3:2] == 2'b10) ? p1_reg : 48'd0);
    end
    assign d1_p = p1_reg;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [47:0] sum;
        int          rise;
    } exp_t;
    exp_t        exp_q[$];
    logic [7:0]  exp_op [int];
    int          last_rise = -1;
    int          first_acc = -1;

    logic [17:0] ba [4];
    logic [17:0] bb [4];
    int          gap [4];

    function automatic void chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [17:0] rnd18();
        if ($urandom_range(0, 3) == 0) return 18'h3FFFF;
        return 18'($urandom);
    endfunction

    // m_ready driver: 0 = low, 1 = high, 2 = random
    int rdy_mode = 0;
    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       bus.m_ready = 1'b0;
                1:       bus.m_ready = 1'b1;
                default: bus.m_ready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // Monitor: opcode checks, result data/timing, hold behaviour in OUT
    initial begin
        bit   prev_mv = 0;
        bit   have_cur = 0;
        exp_t cur;
        int   pulse_chk = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_mv = 0;
                have_cur = 0;
                pulse_chk = -1;
            end else begin
                if (exp_op.exists(cyc)) begin
                    chk("opmode", 48'(dsp_opmode), 48'(exp_op[cyc]));
                    exp_op.delete(cyc);
                end
                if (pulse_chk == cyc) chk("m_valid_pulse", 48'(bus.m_valid), 48'd0);
                if (bus.m_valid && !prev_mv) begin
                    last_rise = cyc;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 48'(bus.m_valid), 48'd0);
                    end else begin
                        cur = exp_q.pop_front();
                        have_cur = 1;
                        chk("result", bus.m_data, cur.sum);
                        chk("rise_cycle", 48'(cyc), 48'(cur.rise));
                    end
                    if (bus.m_ready) pulse_chk = cyc + 1;
                end
                if (bus.m_valid && have_cur) begin
                    chk("out_hold_data", bus.m_data, cur.sum);
                    chk("out_s_ready", 48'(bus.s_ready), 48'd0);
                    chk("out_busy", 48'(busy), 48'd1);
                end
                if (!bus.m_valid) have_cur = 0;
                if (exp_q.size() > 0 && cyc > exp_q[0].rise) begin
                    chk("result_timeout", 48'(cyc), 48'(exp_q[0].rise));
                    void'(exp_q.pop_front());
                end
                prev_mv = bus.m_valid;
            end
        end
    end

    // Offer one pair; returns the accept cycle. Entered and left at posedge+1.
    task automatic send(input logic [17:0] a, input logic [17:0] b, output int acc_cyc, output bit ok);
        ok = 0;
        acc_cyc = -1;
        bus.s_valid = 1'b1;
        bus.s_a = a;
        bus.s_b = b;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.s_ready) begin
                acc_cyc = cyc;
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 48'd0, 48'd1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    // Send a batch of taps from ba/bb with gap[k] bubbles before tap k
    task automatic run_batch(input int ntaps, input int rdy_after_first);
        logic [47:0] sum;
        int acc;
        bit ok;
        sum = '0;
        acc = 0;
        for (int k = 0; k < ntaps; k++) begin
            if (k > 0 && gap[k] > 0) begin
                for (int g = 0; g < gap[k]; g++) exp_op[acc + 2 + g] = 8'h08;
                repeat (gap[k]) begin
                    @(posedge clk);
                    #1;
                end
            end
            send(ba[k], bb[k], acc, ok);
            if (!ok) return;
            exp_op[acc + 1] = (k == 0) ? 8'h01 : 8'h09;
            sum += 48'(ba[k]) * 48'(bb[k]);
            if (k == 0) begin
                first_acc = acc;
                if (rdy_after_first >= 0) rdy_mode = rdy_after_first;
            end
        end
        exp_op[acc + 2] = 8'h08;
        exp_q.push_back('{sum, acc + ML + 2});
    endtask

    task automatic load_small();
        for (int k = 0; k < 4; k++) begin
            ba[k] = 18'(2 * k + 1);
            bb[k] = 18'(2 * k + 2);
            gap[k] = 0;
        end
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int  acc;
        bit  ok;
        int  t0;
        bit  found;

        bus.s_valid = 1'b0;
        bus.s_a = '0;
        bus.s_b = '0;
        bus1.s_valid = 1'b0;
        bus1.s_a = '0;
        bus1.s_b = '0;
        bus1.m_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_m_valid", 48'(bus.m_valid), 48'd0);
        chk("rst_m_data", bus.m_data, 48'd0);
        chk("rst_s_ready", 48'(bus.s_ready), 48'd0);
        chk("rst_busy", 48'(busy), 48'd0);
        chk("rst_opmode", 48'(dsp_opmode), 48'd0);
        chk("rst_dsp_a", 48'(dsp_a), 48'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_clr_opmode", 48'(dsp_opmode), 48'h00);
        chk("idle_s_ready", 48'(bus.s_ready), 48'd1);
        @(posedge clk);
        #1;

        // Back-to-back batch, consumer always ready
        rdy_mode = 1;
        load_small();
        run_batch(4, -1);

        // Same pairs with 2 bubbles before 3rd; must be accepted right after pulse
        gap[2] = 2;
        run_batch(4, 0);
        chk("idle_accept_after_pulse", 48'(first_acc), 48'(last_rise + 1));

        // Hold result with m_ready low for 5 cycles
        found = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.m_valid) begin
                found = 1;
                break;
            end
        end
        if (!found) chk("wait_m_valid", 48'd0, 48'd1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        rdy_mode = 1;

        // Full-scale operands, previous sum must not leak in
        for (int k = 0; k < 4; k++) begin
            ba[k] = 18'h3FFFF;
            bb[k] = 18'h3FFFF;
            gap[k] = 0;
        end
        run_batch(4, -1);

        // Reset after two accepted taps
        load_small();
        send(ba[0], bb[0], acc, ok);
        send(ba[1], bb[1], acc, ok);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_op.delete();
        repeat (2) begin
            @(negedge clk);
            chk("midrst_m_valid", 48'(bus.m_valid), 48'd0);
            chk("midrst_s_ready", 48'(bus.s_ready), 48'd0);
            chk("midrst_busy", 48'(busy), 48'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 48'(busy), 48'd0);
        @(posedge clk);
        #1;
        run_batch(4, -1);

        // Random batches with random bubbles and random m_ready
        rdy_mode = 2;
        for (int b = 0; b < 25; b++) begin
            for (int k = 0; k < 4; k++) begin
                ba[k] = rnd18();
                bb[k] = rnd18();
                gap[k] = $urandom_range(0, 2);
            end
            run_batch(4, -1);
        end
        rdy_mode = 1;
        found = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.m_valid) begin
                found = 1;
                break;
            end
        end
        if (!found) chk("drain_timeout", 48'(exp_q.size()), 48'd0);
        @(posedge clk);
        #1;

        // Single-tap instance: straight to DRAIN
        bus1.m_ready = 1'b1;
        bus1.s_a = 18'd5;
        bus1.s_b = 18'd7;
        bus1.s_valid = 1'b1;
        ok = 0;
        t0 = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus1.s_ready) begin
                t0 = cyc;
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus1.s_valid = 1'b0;
        if (!ok) begin
            chk("n1_accept_timeout", 48'd0, 48'd1);
        end else begin
            @(negedge clk);
            chk("n1_busy_drain", 48'(busy1), 48'd1);
            chk("n1_s_ready_drain", 48'(bus1.s_ready), 48'd0);
            found = 0;
            for (int n = 0; n < 20; n++) begin
                if (bus1.m_valid) begin
                    found = 1;
                    break;
                end
                @(negedge clk);
            end
            if (!found) begin
                chk("n1_result_timeout", 48'd0, 48'd1);
            end else begin
                chk("n1_rise_cycle", 48'(cyc), 48'(t0 + ML + 2));
                chk("n1_result", bus1.m_data, 48'd35);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
